// File: rtl/aes_model_pack.sv
// aes_model_pack: shared state layout, S-box, rcon stepping, round helper
// functions and the sequencer FSM state enum. Used by aes_round_sequencer
// and aes_key_step.
package aes_model_pack;

   localparam int COLUMN_COUNT         = 4;
   localparam int COLUMN_SIZE_IN_BYTES = 4;

   // Element [c][r] is column c, row r; byte 0 of a FIPS-197 vector is [0][0].
   typedef logic [COLUMN_COUNT-1:0][COLUMN_SIZE_IN_BYTES-1:0][7:0] byte_table;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // rcon sequence 01,02,04,...,80,1B,36 is repeated doubling.
   function automatic logic [7:0] rcon_double(input logic [7:0] rc);
      return xtime(rc);
   endfunction

   function automatic byte_table sub_bytes(input byte_table t);
      byte_table res;
      for (int c = 0; c < COLUMN_COUNT; c++)
         for (int r = 0; r < COLUMN_SIZE_IN_BYTES; r++)
            res[2'(c)][2'(r)] = SBOX[t[2'(c)][2'(r)]];
      return res;
   endfunction

   // Row r rotates left by r columns; the 2-bit index wraps mod 4.
   function automatic byte_table shift_rows(input byte_table t);
      byte_table res;
      for (int c = 0; c < COLUMN_COUNT; c++)
         for (int r = 0; r < COLUMN_SIZE_IN_BYTES; r++)
            res[2'(c)][2'(r)] = t[2'(c + r)][2'(r)];
      return res;
   endfunction

   function automatic byte_table mix_columns(input byte_table t);
      byte_table  res;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < COLUMN_COUNT; c++) begin
         a0 = t[2'(c)][0];
         a1 = t[2'(c)][1];
         a2 = t[2'(c)][2];
         a3 = t[2'(c)][3];
         res[2'(c)][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         res[2'(c)][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         res[2'(c)][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         res[2'(c)][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, purely combinational.
// next_key = expansion of key with the given rcon.
module aes_key_step
   import aes_model_pack::*;
(
   input  byte_table  key_i,
   input  logic [7:0] rcon_i,
   output byte_table  next_key_o
);

   logic [COLUMN_SIZE_IN_BYTES-1:0][7:0] temp;

   // RotWord + SubWord on the last column, rcon into row 0, then chain columns.
   always_comb begin
      // NOTE: every output bit is assigned on every pass, so no latch is inferred.
      temp = '0;
      for (int r = 0; r < COLUMN_SIZE_IN_BYTES; r++)
         temp[2'(r)] = SBOX[key_i[3][2'(r + 1)]];
      temp[0]       = temp[0] ^ rcon_i;
      next_key_o    = '0;
      next_key_o[0] = key_i[0] ^ temp;
      next_key_o[1] = key_i[1] ^ next_key_o[0];
      next_key_o[2] = key_i[2] ^ next_key_o[1];
      next_key_o[3] = key_i[3] ^ next_key_o[2];
   end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per cycle.
// Accepts a job in IDLE, runs NUM_ROUNDS rounds in ROUND, holds the result
// in DONE until taken. Optional round_idx debug port: AES_ROUND_IDX_EN.
module aes_round_sequencer
   import aes_model_pack::*;
#(
   parameter int NUM_ROUNDS = 10
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  byte_table  in_block,
   input  byte_table  in_key,
   output logic       out_valid,
   input  logic       out_ready,
   output byte_table  out_block,
   output logic       busy
`ifdef AES_ROUND_IDX_EN
   ,
   output logic [3:0] round_idx
`endif
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   aes_fsm_e   fsm_q;
   byte_table  state_q;
   byte_table  key_q;
   logic [3:0] cnt_q;
   logic [7:0] rcon_q;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       busy_q;

   byte_table  next_key_d;
   byte_table  shifted_d;
   byte_table  mixed_d;
   byte_table  state_d;
   logic       last_round_d;

   aes_key_step u_key_step (
      .key_i      (key_q),
      .rcon_i     (rcon_q),
      .next_key_o (next_key_d)
   );

   // One full round of the state datapath; MixColumns bypassed on the final round.
   always_comb begin
      last_round_d = (cnt_q == LAST_ROUND);
      shifted_d    = shift_rows(sub_bytes(state_q));
      mixed_d      = mix_columns(shifted_d);
      state_d      = (last_round_d ? shifted_d : mixed_d) ^ next_key_d;
   end

   // Control FSM with registered handshake outputs and the round registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         rcon_q      <= 8'h01;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  state_q    <= in_block ^ in_key;
                  key_q      <= in_key;
                  cnt_q      <= 4'd1;
                  rcon_q     <= 8'h01;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  fsm_q      <= ROUND;
               end
            end
            ROUND: begin
               state_q <= state_d;
               key_q   <= next_key_d;
               rcon_q  <= rcon_double(rcon_q);
               if (last_round_d) begin
                  out_valid_q <= 1'b1;
                  fsm_q       <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  cnt_q       <= '0;
                  fsm_q       <= IDLE;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_block = state_q;
   assign busy      = busy_q;

`ifdef AES_ROUND_IDX_EN
   // Counter is 0 in IDLE and parks at NUM_ROUNDS in DONE, so it is the index.
   assign round_idx = cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: table-driven and randomized checks of
// aes_round_sequencer against a byte-level AES-128 model built from GF(2^8)
// arithmetic. Also exercises backpressure, busy-input, mid-job reset and
// back-to-back jobs. Define AES_ROUND_IDX_EN to also check round_idx.
module tb_aes_round_sequencer;
   import aes_model_pack::*;

   localparam int NR = 10;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      in_valid = 1'b0;
   logic      in_ready;
   byte_table in_block = '0;
   byte_table in_key = '0;
   logic      out_valid;
   logic      out_ready = 1'b0;
   byte_table out_block;
   logic      busy;
`ifdef AES_ROUND_IDX_EN
   logic [3:0] round_idx;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   aes_round_sequencer #(.NUM_ROUNDS(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block),
      .busy      (busy)
`ifdef AES_ROUND_IDX_EN
      ,
      .round_idx (round_idx)
`endif
   );

   // ---------------- reference model ----------------
   logic [7:0] sbm [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_aes(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] w [176];
      logic [7:0] tmp [4];
      logic [7:0] a [4];
      logic [7:0] x, rc;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         s[i] = pt[127 - 8*i -: 8];
         w[i] = k[127 - 8*i -: 8];
      end
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
         if (i % 4 == 0) begin
            x = tmp[0];
            tmp[0] = sbm[tmp[1]] ^ rc;
            tmp[1] = sbm[tmp[2]];
            tmp[2] = sbm[tmp[3]];
            tmp[3] = sbm[x];
            rc = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
      for (int rnd = 1; rnd <= NR; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbm[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
         if (rnd != NR) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
               s[4*c+0] = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
               s[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
               s[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
               s[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd + i];
      end
      for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- helpers ----------------
   function automatic byte_table to_tab(input logic [127:0] v);
      byte_table t;
      for (int i = 0; i < 16; i++) t[i/4][i%4] = v[127 - 8*i -: 8];
      return t;
   endfunction

   function automatic logic [127:0] from_tab(input byte_table t);
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = t[i/4][i%4];
      return v;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Wait (bounded) for in_ready, present a job, let it be accepted, scramble inputs.
   task automatic start_job(input logic [127:0] b, input logic [127:0] k);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      check("in_ready_before_start", 128'(in_ready), 128'(1));
      in_block = to_tab(b);
      in_key   = to_tab(k);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_block = to_tab(rand128());
      in_key   = to_tab(rand128());
      check("in_ready_after_accept", 128'(in_ready), 128'(0));
      check("busy_after_accept", 128'(busy), 128'(1));
   endtask

   // Run rounds with junk on the inputs until out_valid; lat = edges after acceptance.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
`ifdef AES_ROUND_IDX_EN
         check("round_idx_in_round", 128'(round_idx), 128'(lat + 1));
`endif
         in_valid = 1'($urandom_range(0, 1));
         in_block = to_tab(rand128());
         in_key   = to_tab(rand128());
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check("out_valid_seen", 128'(out_valid), 128'(1));
`ifdef AES_ROUND_IDX_EN
      check("round_idx_in_done", 128'(round_idx), 128'(NR));
`endif
   endtask

   task automatic run_job(input string name, input logic [127:0] b,
                          input logic [127:0] k, input logic [127:0] exp);
      int lat;
      out_ready = 1'b1;
      start_job(b, k);
      wait_done(lat);
      check({name, "_latency"}, 128'(lat), 128'(NR));
      check({name, "_out_block"}, from_tab(out_block), exp);
      tick();
      check({name, "_out_valid_drop"}, 128'(out_valid), 128'(0));
      check({name, "_in_ready_back"}, 128'(in_ready), 128'(1));
   endtask

   typedef struct {
      string        name;
      logic [127:0] blk;
      logic [127:0] key;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   vec_t vecs [6];

   initial begin
      int lat, seen, rise_cyc, acc_cyc;
      logic ready_before;
      build_sbox();

      vecs[0] = '{"fips_b", B_PT, B_KEY, B_CT};
      vecs[1] = '{"fips_c1", C_PT, C_KEY, C_CT};
      for (int i = 2; i < 6; i++) begin
         vecs[i].name = $sformatf("rand%0d", i);
         vecs[i].blk  = rand128();
         vecs[i].key  = rand128();
         vecs[i].exp  = model_aes(vecs[i].blk, vecs[i].key);
      end

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_in_ready", 128'(in_ready), 128'(1));
`ifdef AES_ROUND_IDX_EN
      check("reset_round_idx", 128'(round_idx), 128'(0));
`endif

      // Table-driven jobs (busy-time input toggling happens inside wait_done)
      for (int i = 0; i < 6; i++) run_job(vecs[i].name, vecs[i].blk, vecs[i].key, vecs[i].exp);

      // Backpressure: hold out_ready low for 5 cycles in DONE
      out_ready = 1'b0;
      start_job(B_PT, B_KEY);
      wait_done(lat);
      check("bp_latency", 128'(lat), 128'(NR));
      check("bp_out_block", from_tab(out_block), B_CT);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_out_valid_held", 128'(out_valid), 128'(1));
         check("bp_out_block_stable", from_tab(out_block), B_CT);
         check("bp_in_ready_low", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 128'(in_ready), 128'(1));
      check("bp_release_out_valid", 128'(out_valid), 128'(0));

      // Reset mid-job at round 5
      start_job(C_PT, C_KEY);
      for (int i = 0; i < 4; i++) tick();
`ifdef AES_ROUND_IDX_EN
      check("midrst_round_idx_5", 128'(round_idx), 128'(5));
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_in_ready", 128'(in_ready), 128'(1));
      check("midrst_out_valid", 128'(out_valid), 128'(0));
      check("midrst_busy", 128'(busy), 128'(0));
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midrst_no_out_valid", 128'(seen), 128'(0));
      run_job("after_reset_c1", C_PT, C_KEY, C_CT);

      // Back-to-back with out_ready tied high and in_valid held
      out_ready = 1'b1;
      in_block  = to_tab(B_PT);
      in_key    = to_tab(B_KEY);
      in_valid  = 1'b1;
      tick();
      in_block = to_tab(C_PT);
      in_key   = to_tab(C_KEY);
      lat = 0;
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
      rise_cyc = cyc;
      check("b2b_first_latency", 128'(lat), 128'(NR));
      check("b2b_first_out_block", from_tab(out_block), B_CT);
      acc_cyc = -100;
      for (int i = 0; i < 10; i++) begin
         ready_before = in_ready;
         tick();
         if (ready_before && in_valid) begin
            acc_cyc = cyc;
            break;
         end
      end
      in_valid = 1'b0;
      check("b2b_accept_gap", 128'(acc_cyc - rise_cyc), 128'(2));
      wait_done(lat);
      check("b2b_second_latency", 128'(lat), 128'(NR));
      check("b2b_second_out_block", from_tab(out_block), C_CT);
      tick();
      check("b2b_final_in_ready", 128'(in_ready), 128'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
